// File: rtl/vga_scandouble_pkg.sv
// Shared VGA line timing constants, so the hsync generator and the line doubler agree.
// The doubler takes its parameter defaults from here.
package vga_scandouble_pkg;

   localparam int SD_PIX_W    = 6;    // RGB 2:2:2
   localparam int SD_LINE_LEN = 448;  // TV samples per line == VGA clocks per line
   localparam int SD_HPERIOD  = 896;  // TV line period in 28 MHz clocks
   localparam int SD_AW       = 9;

endpackage

// File: rtl/vga_linebuf.sv
// Two-bank line store as a simple dual-port RAM: one write port, one registered read port.
// No reset, so synthesis can map it onto block RAM.
module vga_linebuf #(
   parameter int PIX_W = 6,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             rd_bank,
   input  logic [AW-1:0]    rd_addr,
   output logic [PIX_W-1:0] rd_q
);

   logic [PIX_W-1:0] mem [2**(AW+1)];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_addr}] <= wr_data;
      end
      rd_q <= mem[{rd_bank, rd_addr}];
   end

endmodule

// File: rtl/vga_scandouble.sv
// Line doubler: captures a TV line at the 14 MHz strobe rate into one bank.
// At the same time it replays the other bank twice at 28 MHz, aligned to the shared hsync_start.
module vga_scandouble
   import vga_scandouble_pkg::*;
#(
   parameter int PIX_W    = SD_PIX_W,
   parameter int LINE_LEN = SD_LINE_LEN,
   parameter int AW       = SD_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hsync_start,
   input  logic             pix_stb,
   input  logic [PIX_W-1:0] pix_in,
   output logic [PIX_W-1:0] pix_out,
   output logic             pix_valid
);

   // Strobe semantics: hsync_start and pix_stb are single-cycle qualifiers with no
   // back-pressure; a sample is taken in exactly the cycle pix_stb is high.

   // waddr is one bit wider than the bank address so it can sit at LINE_LEN.
   localparam logic [AW:0]   WLIM  = (AW+1)'(LINE_LEN);
   localparam logic [AW-1:0] RLAST = AW'(LINE_LEN - 1);

   logic             wbank_q, wbank_d;
   logic [AW:0]      waddr_q, waddr_d;
   logic             rbank_q, rbank_d;
   logic [AW-1:0]    raddr_q, raddr_d;
   logic             rd_ok_q, rd_ok_d;
   logic             rd_ok_p1_q, rd_ok_p1_d;
   logic [PIX_W-1:0] pix_out_q, pix_out_d;
   logic             pix_valid_q, pix_valid_d;

   logic             wr_en;
   logic             wr_bank;
   logic [AW-1:0]    wr_addr;
   logic [PIX_W-1:0] ram_q;

   // Write side. Turnover wins over a coincident strobe, which lands at address 0 of the new bank.
   always_comb begin
      wbank_d = wbank_q;
      waddr_d = waddr_q;
      wr_en   = 1'b0;
      wr_bank = wbank_q;
      wr_addr = waddr_q[AW-1:0];
      if (hsync_start) begin
         wbank_d = ~wbank_q;
         wr_bank = ~wbank_q;
         wr_addr = '0;
         wr_en   = pix_stb;
         waddr_d = pix_stb ? (AW+1)'(1) : '0;
      end else if (pix_stb && (waddr_q < WLIM)) begin
         wr_en   = 1'b1;
         waddr_d = waddr_q + 1'b1;
      end
   end

   // Read side. A line that did not fill exactly LINE_LEN samples is never replayed.
   always_comb begin
      rbank_d = rbank_q;
      rd_ok_d = rd_ok_q;
      raddr_d = (raddr_q == RLAST) ? '0 : raddr_q + 1'b1;
      if (hsync_start) begin
         rbank_d = wbank_q;
         raddr_d = '0;
         rd_ok_d = (waddr_q == WLIM);
      end
   end

   // rd_ok travels alongside the RAM read so an rd_ok change lands exactly on sample 0.
   always_comb begin
      rd_ok_p1_d  = rd_ok_q;
      pix_valid_d = rd_ok_p1_q;
      pix_out_d   = rd_ok_p1_q ? ram_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbank_q     <= 1'b0;
         waddr_q     <= '0;
         rbank_q     <= 1'b0;
         raddr_q     <= '0;
         rd_ok_q     <= 1'b0;
         rd_ok_p1_q  <= 1'b0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         wbank_q     <= wbank_d;
         waddr_q     <= waddr_d;
         rbank_q     <= rbank_d;
         raddr_q     <= raddr_d;
         rd_ok_q     <= rd_ok_d;
         rd_ok_p1_q  <= rd_ok_p1_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   vga_linebuf #(
      .PIX_W (PIX_W),
      .AW    (AW)
   ) u_linebuf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr),
      .wr_data (pix_in),
      .rd_bank (rbank_q),
      .rd_addr (raddr_q),
      .rd_q    (ram_q)
   );

   assign pix_out   = pix_out_q;
   assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_scandouble.sv
// Line-by-line bench for vga_scandouble: each table row is one TV line, with a capture pattern
// and the replay that row must show.
module tb_vga_scandouble;

   localparam int PIX_W    = 6;
   localparam int LINE_LEN = 448;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             hsync_start = 1'b0;
   logic             pix_stb = 1'b0;
   logic [PIX_W-1:0] pix_in = '0;
   logic [PIX_W-1:0] pix_out;
   logic             pix_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int period;     // clocks from this hsync_start to the next
      int n_stb;      // strobes issued in this line
      int every;      // strobe spacing in clocks
      int off;        // clock of the first strobe (0 = coincident with hsync_start)
      int base;       // pix_in of strobe k is base+k (mod 64)
      bit exp_valid;  // replay shown during this line is buffered data
      int exp_base;   // replay sample k is exp_base+k (mod 64)
   } row_t;

   row_t rows[12];

   vga_scandouble dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hsync_start (hsync_start),
      .pix_stb     (pix_stb),
      .pix_in      (pix_in),
      .pix_out     (pix_out),
      .pix_valid   (pix_valid)
   );

   always #5 clk = ~clk;

   task automatic check_out(input string name, input logic [PIX_W-1:0] exp_pix, input logic exp_vld);
      checks++;
      if (pix_out !== exp_pix || pix_valid !== exp_vld) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: pix_out=%h pix_valid=%b, expected pix_out=%h pix_valid=%b",
                     name, pix_out, pix_valid, exp_pix, exp_vld);
      end
   endtask

   // One TV line: hsync_start at clock 0. The observation in iteration c reflects the edge before it,
   // so replay sample 0 (two edges after the hsync edge) is observed at c=3.
   task automatic run_row(input int r);
      int cnt;
      int idx;
      logic [PIX_W-1:0] exp_pix;
      cnt = 0;
      for (int c = 0; c < rows[r].period; c++) begin
         @(negedge clk);
         if (c >= 3) begin
            idx = (c - 3) % LINE_LEN;
            exp_pix = rows[r].exp_valid ? PIX_W'(rows[r].exp_base + idx) : '0;
            check_out($sformatf("row%0d_c%0d", r, c), exp_pix, rows[r].exp_valid);
         end
         hsync_start = (c == 0);
         if (cnt < rows[r].n_stb && c >= rows[r].off && ((c - rows[r].off) % rows[r].every) == 0) begin
            pix_stb = 1'b1;
            pix_in  = PIX_W'(rows[r].base + cnt);
            cnt++;
         end else begin
            pix_stb = 1'b0;
            pix_in  = '0;
         end
      end
   endtask

   initial begin
      //         period n_stb every off base   exp  exp_base
      rows[0]  = '{896, 448, 2, 1, 0,     1'b0, 0};     // first line after reset: black
      rows[1]  = '{896, 448, 2, 1, 0,     1'b1, 0};     // replay of line 1: 0..63 repeating, twice
      rows[2]  = '{896, 300, 2, 1, 5,     1'b1, 0};     // short capture
      rows[3]  = '{896, 448, 2, 1, 9,     1'b0, 0};     // short line is not replayed
      rows[4]  = '{896, 460, 1, 1, 17,    1'b1, 9};     // over-long capture
      rows[5]  = '{896, 448, 2, 0, 'h2A,  1'b1, 17};    // only samples 0..447 replayed; strobe on hsync
      rows[6]  = '{700, 448, 1, 1, 33,    1'b1, 'h2A};  // coincident sample is 2A; early next hsync
      rows[7]  = '{896, 448, 2, 1, 40,    1'b1, 33};    // replay restarts at sample 0 after early hsync
      rows[8]  = '{896, 0,   2, 1, 0,     1'b1, 40};
      rows[9]  = '{896, 448, 2, 1, 50,    1'b0, 0};     // previous line was empty
      rows[10] = '{896, 448, 2, 1, 3,     1'b0, 0};     // first line after mid-replay reset: black
      rows[11] = '{896, 0,   2, 1, 0,     1'b1, 3};

      // Reset state
      repeat (3) @(negedge clk);
      check_out("reset_hold", '0, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_out("after_release", '0, 1'b0);

      for (int r = 0; r < 10; r++) run_row(r);

      // Partial line replaying row 9's data, then an asynchronous reset mid-replay
      begin
         row_t part;
         part = '{200, 0, 2, 1, 0, 1'b1, 50};
         rows[9] = part;  // row 9 slot reused only for its label in FAIL lines
         run_row(9);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_out("async_reset", '0, 1'b0);
      repeat (3) @(negedge clk);
      check_out("reset_held_mid_line", '0, 1'b0);
      rst_n = 1'b1;

      for (int r = 10; r < 12; r++) run_row(r);

      @(negedge clk);
      hsync_start = 1'b0;
      pix_stb     = 1'b0;
      pix_in      = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
